// File: rtl/arcade_input_conditioner_if.sv
// rtl/arcade_input_conditioner_if.sv - joystick/button bundle between hps_io and the conditioner
//
// Purpose: groups the joystick words, mode/autofire controls and the conditioned
// core-side outputs so the conditioner can be dropped between hps_io and the core.
// Signals:
//   joy_in         NPLAYERS*32  hps_io joystick words, player p at [32p+31:32p]
//   mode           2            stick mode select
//   autofire_en    NFIRE        per-fire-button autofire enable
//   ja             8            active-low stick word to core
//   btn            3            active-high {start1,start2,coin} to core
//   paused         1            pause latch
//   active_player  2            last player with a nonzero joystick word
// Modports: master drives the inputs and observes the outputs; slave is the conditioner.

interface arcade_input_conditioner_if #(
    parameter int NPLAYERS = 2,
    parameter int NFIRE    = 4
);
    logic [NPLAYERS*32-1:0] joy_in;
    logic [1:0]             mode;
    logic [NFIRE-1:0]       autofire_en;
    logic [7:0]             ja;
    logic [2:0]             btn;
    logic                   paused;
    logic [1:0]             active_player;

    modport master (
        output joy_in, mode, autofire_en,
        input  ja, btn, paused, active_player
    );

    modport slave (
        input  joy_in, mode, autofire_en,
        output ja, btn, paused, active_player
    );
endinterface

// File: rtl/arcade_input_conditioner.sv
// rtl/arcade_input_conditioner.sv - registered joystick/button conditioner for Williams-family cores
//
// Purpose: ORs N player joystick words together, maps them onto the core's active-low
// JA word (move + aim nibbles) in one of three stick modes, stretches coin pulses,
// latches a pause toggle, applies per-button autofire and tracks the last active player.
// Ports:
//   clk_sys   in  system clock, all logic on the rising edge
//   reset     in  synchronous, active-high
//   bus       slave modport of arcade_input_conditioner_if (joy_in, mode, autofire_en
//             in; ja, btn, paused, active_player out)

module arcade_input_conditioner #(
    parameter int NPLAYERS     = 2,
    parameter int NFIRE        = 4,
    parameter int COIN_MIN_CYC = 600000,
    parameter int AUTOFIRE_DIV = 200000
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    arcade_input_conditioner_if.slave    bus
);

    localparam int CW = $clog2(COIN_MIN_CYC + 1);
    localparam int AW = $clog2(AUTOFIRE_DIV + 1);
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_MIN_CYC - 1);
    localparam logic [AW-1:0] AF_LAST   = AW'(AUTOFIRE_DIV - 1);

    // Combined (all-player) controls
    logic [3:0]       dir_all;
    logic [NFIRE-1:0] fire_all;
    logic             start1_all;
    logic             start2_all;
    logic             coin_all;
    logic             pause_all;

    // Per-player directions used by split mode
    logic [3:0]       dir_p0;
    logic [3:0]       dir_p1;

    logic [NFIRE-1:0] fire_out;
    logic [3:0]       aim;
    logic [3:0]       move;

    logic [1:0]       ap_next;
    logic             found;

    // Registered state
    logic [7:0]       ja_r;
    logic [2:1]       start_r;
    logic             coin_out_r;
    logic             paused_r;
    logic [1:0]       active_player_r;
    logic             coin_prev;
    logic             pause_prev;
    logic [CW-1:0]    coin_cnt;
    logic [AW-1:0]    af_cnt;
    logic             af_phase;

    logic             coin_edge;
    logic             pause_edge;
    logic             coin_load;
    logic             paused_next;

    // OR-combine every player and find the lowest-index active player.
    always_comb begin
        dir_all    = '0;
        fire_all   = '0;
        start1_all = 1'b0;
        start2_all = 1'b0;
        coin_all   = 1'b0;
        pause_all  = 1'b0;
        ap_next    = active_player_r;
        found      = 1'b0;
        for (int p = 0; p < NPLAYERS; p++) begin
            dir_all    = dir_all    | bus.joy_in[32*p +: 4];
            fire_all   = fire_all   | bus.joy_in[32*p+4 +: NFIRE];
            start1_all = start1_all | bus.joy_in[32*p+10];
            start2_all = start2_all | bus.joy_in[32*p+11];
            coin_all   = coin_all   | bus.joy_in[32*p+12];
            pause_all  = pause_all  | bus.joy_in[32*p+15];
            if (!found && (|bus.joy_in[32*p +: 32])) begin
                ap_next = 2'(p);
                found   = 1'b1;
            end
        end
    end

    assign dir_p0 = bus.joy_in[3:0];

    // With a single player there is no second stick; its direction reads as released.
    generate
        if (NPLAYERS > 1) begin : g_p1
            assign dir_p1 = bus.joy_in[35:32];
        end else begin : g_no_p1
            assign dir_p1 = 4'h0;
        end
    endgenerate

    // Autofire gates a held button with the square-wave phase; phase starts at 1
    // so a fresh press after reset fires immediately.
    assign fire_out = fire_all & (~bus.autofire_en | {NFIRE{af_phase}});

    // Nibble bit order follows the joystick word: bit0 R, bit1 L, bit2 D, bit3 U.
    always_comb begin
        aim  = ~{fire_out[0], fire_out[3], fire_out[1], fire_out[2]};
        move = ~dir_all;
        case (bus.mode)
            2'd1: aim = ~dir_all;
            2'd2: begin
                aim  = ~dir_p1;
                move = ~dir_p0;
            end
            default: ;
        endcase
    end

    assign coin_edge   = coin_all & ~coin_prev;
    assign pause_edge  = pause_all & ~pause_prev;
    // Only an idle stretcher accepts a new coin; edges mid-pulse never extend it.
    assign coin_load   = coin_edge && (coin_cnt == '0);
    assign paused_next = paused_r ^ pause_edge;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ja_r            <= 8'hFF;
            start_r         <= 2'b00;
            coin_out_r      <= 1'b0;
            paused_r        <= 1'b0;
            active_player_r <= 2'd0;
            coin_prev       <= 1'b0;
            pause_prev      <= 1'b0;
            coin_cnt        <= '0;
            af_cnt          <= '0;
            af_phase        <= 1'b1;
        end else begin
            coin_prev       <= coin_all;
            pause_prev      <= pause_all;
            paused_r        <= paused_next;
            active_player_r <= ap_next;
            start_r         <= {start1_all, start2_all};

            // Stick is blanked in the same cycle the pause latch reads 1.
            ja_r <= paused_next ? 8'hFF : {aim, move};

            if (af_cnt == AF_LAST) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end

            // Loading COIN_MIN_CYC-1 plus the edge cycle itself gives exactly
            // COIN_MIN_CYC cycles of btn[0].
            if (coin_load) begin
                coin_cnt <= COIN_LOAD;
            end else if (coin_cnt != '0) begin
                coin_cnt <= coin_cnt - 1'b1;
            end
            coin_out_r <= (coin_cnt != '0) | coin_edge;
        end
    end

    assign bus.ja            = ja_r;
    assign bus.btn           = {start_r, coin_out_r};
    assign bus.paused        = paused_r;
    assign bus.active_player = active_player_r;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// tb/tb_arcade_input_conditioner.sv - scoreboard bench for arcade_input_conditioner

module tb_arcade_input_conditioner;

    localparam int NP = 2;
    localparam int NF = 4;

    localparam logic [3:0] C_JA  = 4'b0001;
    localparam logic [3:0] C_BTN = 4'b0010;
    localparam logic [3:0] C_PAU = 4'b0100;
    localparam logic [3:0] C_AP  = 4'b1000;
    localparam logic [3:0] C_ALL = 4'b1111;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] ja;
        logic [2:0] btn;
        logic       paused;
        logic [1:0] ap;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    arcade_input_conditioner_if #(.NPLAYERS(NP), .NFIRE(NF)) bus();

    arcade_input_conditioner #(
        .NPLAYERS(NP), .NFIRE(NF), .COIN_MIN_CYC(10), .AUTOFIRE_DIV(4)
    ) dut (
        .clk_sys(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [63:0] pj(input logic [31:0] p0, input logic [31:0] p1);
        return {p1, p0};
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic rst, input logic [63:0] joy, input logic [1:0] md,
                        input logic [3:0] af, input logic [3:0] mask, input logic [7:0] ja,
                        input logic [2:0] btn, input logic pau, input logic [1:0] ap,
                        input string name);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        bus.joy_in      = joy;
        bus.mode        = md;
        bus.autofire_en = af;
        e.mask = mask; e.ja = ja; e.btn = btn; e.paused = pau; e.ap = ap; e.name = name;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: one queued expectation per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask[0]) chk({e.name, ".ja"}, bus.ja, e.ja);
                if (e.mask[1]) chk({e.name, ".btn"}, {5'd0, bus.btn}, {5'd0, e.btn});
                if (e.mask[2]) chk({e.name, ".paused"}, {7'd0, bus.paused}, {7'd0, e.paused});
                if (e.mask[3]) chk({e.name, ".ap"}, {6'd0, bus.active_player}, {6'd0, e.ap});
            end
        end
    end

    initial begin
        logic coin;
        bus.joy_in = '0; bus.mode = 2'd0; bus.autofire_en = '0;

        // Reset state
        step(1, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b000, 0, 0, "reset0");
        step(1, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b000, 0, 0, "reset1");

        // Mode 0: fire-as-aim, combined across players
        step(0, pj(32'h11, 32'h0), 0, 0, C_ALL, 8'h7E, 3'b000, 0, 0, "m0_r_f0");
        step(0, pj(32'h11, 32'h80), 0, 0, C_ALL, 8'h3E, 3'b000, 0, 0, "m0_add_p1f3");
        step(0, pj(32'h0, 32'h80), 0, 0, C_ALL, 8'hBF, 3'b000, 0, 1, "m0_p1_only");
        step(0, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b000, 0, 1, "ap_hold");
        // Mode 1: twin-stick duplicates combined direction
        step(0, pj(32'h1, 32'h8), 1, 0, C_ALL, 8'h66, 3'b000, 0, 0, "m1_twin");
        // Mode 2: split players
        step(0, pj(32'h8, 32'h2), 2, 0, C_ALL, 8'hD7, 3'b000, 0, 0, "m2_split");
        step(0, pj(32'h0, 32'h2), 2, 0, C_ALL, 8'hDF, 3'b000, 0, 1, "m2_p0_rel");
        // Mode 3 behaves as mode 0
        step(0, pj(32'h40, 32'h0), 3, 0, C_ALL, 8'hEF, 3'b000, 0, 0, "m3_f2");
        step(0, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b000, 0, 0, "idle0");

        // Coin held 50 cycles on P1 -> exactly 10 cycles of btn[0]
        for (int i = 0; i < 50; i++)
            step(0, pj(32'h0, 32'h1000), 0, 0, C_JA | C_BTN | C_AP, 8'hFF,
                 {2'b00, (i < 10)}, 0, 1, "coin_hold");
        step(0, 64'h0, 0, 0, C_BTN | C_AP, 8'hFF, 3'b000, 0, 1, "coin_rel0");
        step(0, 64'h0, 0, 0, C_BTN, 8'hFF, 3'b000, 0, 1, "coin_rel1");

        // Re-press at cycle 5 of a pulse must not extend it
        for (int i = 0; i < 15; i++) begin
            coin = (i < 4) || (i >= 5);
            step(0, pj({19'd0, coin, 12'd0}, 32'h0), 0, 0, C_BTN, 8'hFF,
                 {2'b00, (i < 10)}, 0, 0, "coin_repress");
        end
        step(0, 64'h0, 0, 0, C_BTN, 8'hFF, 3'b000, 0, 0, "coin_idle");
        step(0, pj(32'h1000, 32'h0), 0, 0, C_BTN, 8'hFF, 3'b001, 0, 0, "coin_new");
        step(0, pj(32'h1000, 32'h0), 0, 0, C_BTN, 8'hFF, 3'b001, 0, 0, "coin_new1");
        // Reset mid-pulse aborts it
        step(1, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b000, 0, 0, "coin_reset");
        step(0, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b000, 0, 0, "coin_after_rst");

        // Pause toggle, stick blanked, starts still pass
        step(0, pj(32'h8000, 32'h0), 0, 0, C_ALL, 8'hFF, 3'b000, 1, 0, "pause_on");
        step(0, pj(32'h8001, 32'h0), 0, 0, C_ALL, 8'hFF, 3'b000, 1, 0, "pause_hold_r");
        step(0, pj(32'h0401, 32'h0), 0, 0, C_ALL, 8'hFF, 3'b100, 1, 0, "pause_start1");
        step(0, pj(32'h8001, 32'h0), 0, 0, C_ALL, 8'hFE, 3'b000, 0, 0, "pause_off");
        step(0, pj(32'h0001, 32'h0), 0, 0, C_ALL, 8'hFE, 3'b000, 0, 0, "unpaused_r");
        step(0, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b000, 0, 0, "idle1");
        // Coin and pause edges together are both taken
        step(0, pj(32'h9000, 32'h0), 0, 0, C_ALL, 8'hFF, 3'b001, 1, 0, "coin_pause");
        step(0, 64'h0, 0, 0, C_ALL, 8'hFF, 3'b001, 1, 0, "coin_pause1");
        step(0, pj(32'h8000, 32'h0), 0, 0, C_ALL, 8'hFF, 3'b001, 0, 0, "pause_off2");
        for (int i = 3; i < 11; i++)
            step(0, 64'h0, 0, 0, C_BTN | C_PAU, 8'hFF, {2'b00, (i < 10)}, 0, 0, "coin_tail");

        // Autofire on f0, half-period 4, first phase active
        step(1, 64'h0, 0, 4'b0001, C_ALL, 8'hFF, 3'b000, 0, 0, "af_reset");
        for (int k = 0; k < 16; k++)
            step(0, pj(32'h10, 32'h0), 0, 4'b0001, C_JA,
                 ((k / 4) % 2 == 0) ? 8'h7F : 8'hFF, 3'b000, 0, 0, "af_f0");
        // f1 without autofire stays on while f0 keeps toggling
        for (int k = 16; k < 24; k++)
            step(0, pj(32'h30, 32'h0), 0, 4'b0001, C_JA,
                 ((k / 4) % 2 == 0) ? 8'h5F : 8'hDF, 3'b000, 0, 0, "af_f0_f1");

        @(posedge clk);
        #3;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
